// File: rtl/mux_step_master_if.sv
// mux_step_master_if: command/response handshake and Wishbone master bundle
// for the multiplexer single-step sequencer.
interface mux_step_master_if;
    logic        cmd_valid_i;
    logic        cmd_ready_o;
    logic [3:0]  cmd_addr_i;
    logic [7:0]  cmd_steps_i;
    logic [27:0] cmd_io_i;
    logic        rsp_valid_o;
    logic        rsp_ready_i;
    logic [27:0] rsp_data_o;
    logic        rsp_timeout_o;
    logic        busy_o;
    logic        wbm_cyc_o;
    logic        wbm_stb_o;
    logic        wbm_we_o;
    logic [31:0] wbm_adr_o;
    logic [31:0] wbm_dat_o;
    logic [3:0]  wbm_sel_o;
    logic [31:0] wbm_dat_i;
    logic        wbm_ack_i;
    modport master (
        input  cmd_valid_i, cmd_addr_i, cmd_steps_i, cmd_io_i, rsp_ready_i, wbm_dat_i, wbm_ack_i,
        output cmd_ready_o, rsp_valid_o, rsp_data_o, rsp_timeout_o, busy_o,
               wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_adr_o, wbm_dat_o, wbm_sel_o
    );
    modport slave (
        output cmd_valid_i, cmd_addr_i, cmd_steps_i, cmd_io_i, rsp_ready_i, wbm_dat_i, wbm_ack_i,
        input  cmd_ready_o, rsp_valid_o, rsp_data_o, rsp_timeout_o, busy_o,
               wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_adr_o, wbm_dat_o, wbm_sel_o
    );
endinterface

// File: rtl/mux_step_master.sv
// mux_step_master: drives a design multiplexer over Wishbone -- loads IO, selects
// the design, single-steps its clock N times and reads back the design outputs.
module mux_step_master #(
    parameter logic [31:0] CTRL_ADR = 32'h3080_0000,
    parameter logic [31:0] IO_ADR   = 32'h3040_0000,
    parameter int unsigned TIMEOUT  = 16
) (
    input logic               wb_clk_i,
    input logic               wb_rst_n_i,
    mux_step_master_if.master bus
);
    typedef enum logic [2:0] {IDLE, WR_IO, WR_CTRL, CLK_HI, CLK_LO, RD_IO, RESP} state_t;
    state_t      state, state_n;
    logic [1:0]  rst_sync;
    logic        cyc, cyc_n;
    logic [7:0]  wdog, wdog_n;
    logic [7:0]  cnt, cnt_n;
    logic [3:0]  addr, addr_n;
    logic [27:0] io, io_n;
    logic [27:0] data, data_n;
    logic        tout, tout_n;
    logic        accept, ack, expired;
    logic [31:0] ctrl_word;

    // Release of reset is retimed so the first command waits two edges.
    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) rst_sync <= 2'b00;
        else rst_sync <= {rst_sync[0], 1'b1};
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            state <= IDLE;
            cyc   <= 1'b0;
            wdog  <= '0;
            cnt   <= '0;
            addr  <= '0;
            io    <= '0;
            data  <= '0;
            tout  <= 1'b0;
        end else begin
            state <= state_n;
            cyc   <= cyc_n;
            wdog  <= wdog_n;
            cnt   <= cnt_n;
            addr  <= addr_n;
            io    <= io_n;
            data  <= data_n;
            tout  <= tout_n;
        end
    end

    assign accept  = bus.cmd_valid_i & bus.cmd_ready_o;
    assign ack     = cyc & bus.wbm_ack_i;
    // A late ack on the last allowed cycle still wins over the watchdog.
    assign expired = cyc & ~ack & (wdog == 8'(TIMEOUT - 1));

    always_comb begin
        state_n = state;
        cyc_n   = cyc;
        wdog_n  = wdog;
        cnt_n   = cnt;
        addr_n  = addr;
        io_n    = io;
        data_n  = data;
        tout_n  = tout;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_n = WR_IO;
                    addr_n  = bus.cmd_addr_i;
                    io_n    = bus.cmd_io_i;
                    cnt_n   = bus.cmd_steps_i;
                end
            end
            RESP: state_n = bus.rsp_ready_i ? IDLE : RESP;
            default: begin
                if (!cyc) begin
                    cyc_n  = 1'b1;
                    wdog_n = '0;
                end else if (ack) begin
                    cyc_n = 1'b0;
                    case (state)
                        WR_IO:   state_n = WR_CTRL;
                        WR_CTRL: state_n = (cnt == 8'd0) ? RD_IO : CLK_HI;
                        CLK_HI:  state_n = CLK_LO;
                        CLK_LO: begin
                            cnt_n   = cnt - 8'd1;
                            state_n = (cnt == 8'd1) ? RD_IO : CLK_HI;
                        end
                        default: begin
                            state_n = RESP;
                            data_n  = bus.wbm_dat_i[27:0];
                            tout_n  = 1'b0;
                        end
                    endcase
                end else if (expired) begin
                    cyc_n   = 1'b0;
                    state_n = RESP;
                    data_n  = '0;
                    tout_n  = 1'b1;
                end else begin
                    wdog_n = wdog + 8'd1;
                end
            end
        endcase
    end

    assign ctrl_word         = {24'h0, addr, state == CLK_HI, 3'b101};
    assign bus.cmd_ready_o   = (state == IDLE) & rst_sync[1];
    assign bus.busy_o        = state != IDLE;
    assign bus.rsp_valid_o   = state == RESP;
    assign bus.rsp_data_o    = data;
    assign bus.rsp_timeout_o = tout;
    assign bus.wbm_cyc_o     = cyc;
    assign bus.wbm_stb_o     = cyc;
    assign bus.wbm_we_o      = cyc & (state != RD_IO);
    assign bus.wbm_sel_o     = 4'hF;
    assign bus.wbm_adr_o     = !cyc ? 32'h0 : (state == WR_IO || state == RD_IO) ? IO_ADR : CTRL_ADR;
    assign bus.wbm_dat_o     = (!cyc || state == RD_IO) ? 32'h0 : (state == WR_IO) ? {4'h0, io} : ctrl_word;
endmodule

// File: tb/tb_mux_step_master.sv
// tb_mux_step_master: randomized scoreboard bench; a command model predicts every
// Wishbone transaction and response, a behavioural slave/monitor checks them.
module tb_mux_step_master;
    localparam int          TIMEOUT  = 16;
    localparam logic [31:0] CTRL_ADR = 32'h3080_0000;
    localparam logic [31:0] IO_ADR   = 32'h3040_0000;

    typedef struct packed {logic we; logic [31:0] adr; logic [31:0] dat;} tx_t;
    typedef struct packed {logic to; logic [27:0] data;} rsp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b1;

    mux_step_master_if bus();
    mux_step_master #(.CTRL_ADR(CTRL_ADR), .IO_ADR(IO_ADR), .TIMEOUT(TIMEOUT)) dut (
        .wb_clk_i(clk), .wb_rst_n_i(rst_n), .bus(bus)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish, required completion");
        $fatal(1);
    end

    tx_t         exp_tx[$];
    rsp_t        exp_rsp[$];
    int          n_cmp, n_fail;
    int          tx_total, hold_at, fixed_lat, run, lat;
    logic        held, acked_prev, rsp_prev;
    logic [31:0] rd_val;
    tx_t         cap, got;
    rsp_t        rcap, rnow;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h", name, act, req);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    function automatic logic [31:0] ctrl(input logic [3:0] a, input logic c);
        return {24'h0, a, c, 3'b101};
    endfunction

    // Slave + monitor: runs on the falling edge, away from the DUT's sampling edge.
    task automatic mon();
        if (!rst_n) begin
            run = 0;
            acked_prev = 1'b0;
            rsp_prev = 1'b0;
            bus.wbm_ack_i = 1'b0;
            return;
        end
        bus.wbm_ack_i = 1'b0;
        if (acked_prev) check("cyc_gap", bus.wbm_cyc_o, 0);
        acked_prev = 1'b0;
        if (bus.wbm_cyc_o) begin
            if (run == 0) begin
                tx_total++;
                held = (tx_total == hold_at);
                lat = fixed_lat > 0 ? fixed_lat : ($urandom_range(0, 7) == 0 ? TIMEOUT : $urandom_range(1, 3));
                cap = {bus.wbm_we_o, bus.wbm_adr_o, bus.wbm_dat_o};
                bus.wbm_dat_i = bus.wbm_we_o ? $urandom : rd_val;
            end
            run++;
            if (!held && run == lat) begin
                bus.wbm_ack_i = 1'b1;
                acked_prev = 1'b1;
                run = 0;
                got = {bus.wbm_we_o, bus.wbm_adr_o, bus.wbm_dat_o};
                check("tx_stable", got, cap);
                check("stb_sel", {bus.wbm_stb_o, bus.wbm_sel_o}, 5'h1F);
                if (exp_tx.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL tx_unexpected: got %0h required no transaction", got);
                end else check("tx", got, exp_tx.pop_front());
            end
        end else begin
            if (run != 0) begin
                check("timeout_len", run, TIMEOUT);
                check("timeout_held", held, 1);
                run = 0;
            end
            bus.wbm_ack_i = ($urandom_range(0, 3) == 0);
            bus.wbm_dat_i = $urandom;
        end
        if (bus.rsp_valid_o) begin
            rnow = {bus.rsp_timeout_o, bus.rsp_data_o};
            if (!rsp_prev) rcap = rnow;
            else check("rsp_stable", rnow, rcap);
            if (bus.rsp_ready_i) begin
                if (exp_rsp.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL rsp_unexpected: got %0h required no response", rnow);
                end else check("rsp", rnow, exp_rsp.pop_front());
            end
        end
        rsp_prev = bus.rsp_valid_o && !bus.rsp_ready_i;
    endtask

    task automatic issue(input logic [3:0] a, input logic [7:0] s, input logic [27:0] io,
                         input int hold_k, input logic [31:0] rd, input bit want_rsp);
        tx_t seq[$];
        bit  ok = 0;
        seq.push_back(tx_t'({1'b1, IO_ADR, 4'h0, io}));
        seq.push_back(tx_t'({1'b1, CTRL_ADR, ctrl(a, 1'b0)}));
        for (int i = 0; i < int'(s); i++) begin
            seq.push_back(tx_t'({1'b1, CTRL_ADR, ctrl(a, 1'b1)}));
            seq.push_back(tx_t'({1'b1, CTRL_ADR, ctrl(a, 1'b0)}));
        end
        seq.push_back(tx_t'({1'b0, IO_ADR, 32'h0}));
        for (int i = 0; i < seq.size(); i++)
            if (hold_k < 0 || i < hold_k) exp_tx.push_back(seq[i]);
        if (want_rsp) exp_rsp.push_back(hold_k < 0 ? rsp_t'({1'b0, rd[27:0]}) : rsp_t'({1'b1, 28'h0}));
        rd_val = rd;
        hold_at = hold_k < 0 ? 0 : tx_total + hold_k + 1;
        bus.cmd_addr_i = a;
        bus.cmd_steps_i = s;
        bus.cmd_io_i = io;
        bus.cmd_valid_i = 1'b1;
        for (int i = 0; i < 100 && !ok; i++) begin
            if (bus.cmd_ready_o) ok = 1;
            step();
        end
        bus.cmd_valid_i = 1'b0;
        if (!ok) begin
            n_cmp++;
            n_fail++;
            $display("FAIL cmd_accept: cmd_ready_o stayed 0, required 1 within 100 cycles");
        end else check("busy_after_accept", {bus.busy_o, bus.cmd_ready_o}, 2'b10);
    endtask

    task automatic take_rsp(input int delay, input int bound);
        for (int i = 0; i < bound && !bus.rsp_valid_o; i++) step();
        if (!bus.rsp_valid_o) begin
            n_cmp++;
            n_fail++;
            $display("FAIL rsp_wait: rsp_valid_o stayed 0, required 1 within %0d cycles", bound);
            return;
        end
        repeat (delay) step();
        bus.rsp_ready_i = 1'b1;
        step();
        bus.rsp_ready_i = 1'b0;
        check("idle_after_rsp", {bus.rsp_valid_o, bus.busy_o, bus.cmd_ready_o}, 3'b001);
    endtask

    task automatic run_cmd(input logic [3:0] a, input logic [7:0] s, input logic [27:0] io,
                           input int hold_k, input logic [31:0] rd, input int delay);
        int base = tx_total;
        int n = 3 + 2 * int'(s);
        issue(a, s, io, hold_k, rd, 1);
        take_rsp(delay, n * (TIMEOUT + 3) + 20);
        check("tx_count", tx_total - base, hold_k < 0 ? n : hold_k + 1);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        check("reset_outputs", {bus.wbm_cyc_o, bus.wbm_stb_o, bus.wbm_we_o, bus.wbm_adr_o, bus.wbm_dat_o,
                                bus.rsp_valid_o, bus.rsp_data_o, bus.rsp_timeout_o, bus.busy_o, bus.cmd_ready_o}, 0);
        repeat (2) step();
        rst_n = 1'b1;
        step();
        check("ready_edge1", bus.cmd_ready_o, 0);
        step();
        check("ready_edge2", bus.cmd_ready_o, 1);
    endtask

    initial begin
        bus.cmd_valid_i = 1'b0;
        bus.cmd_addr_i = '0;
        bus.cmd_steps_i = '0;
        bus.cmd_io_i = '0;
        bus.rsp_ready_i = 1'b0;
        bus.wbm_ack_i = 1'b0;
        bus.wbm_dat_i = '0;
        n_cmp = 0;
        n_fail = 0;
        tx_total = 0;
        hold_at = 0;
        fixed_lat = 0;
        run = 0;
        held = 1'b0;
        acked_prev = 1'b0;
        rsp_prev = 1'b0;
        rd_val = '0;
        fork
            forever begin
                @(negedge clk);
                mon();
            end
        join_none
        #1;
        do_reset();

        fixed_lat = 2;
        run_cmd(4'h5, 8'd0, 28'h0ABCDEF, -1, 32'h0123_4567, 0);

        fixed_lat = 0;
        run_cmd(4'h8, 8'd3, 28'($urandom), -1, $urandom, 1);

        fixed_lat = 1;
        run_cmd(4'($urandom), 8'd255, 28'($urandom), -1, $urandom, 2);

        fixed_lat = 0;
        run_cmd(4'($urandom), 8'd2, 28'($urandom), 2, $urandom, 1);
        run_cmd(4'($urandom), 8'd1, 28'($urandom), -1, $urandom, 0);

        // response held off while a stray command is offered
        issue(4'hA, 8'd1, 28'($urandom), -1, $urandom, 1);
        for (int i = 0; i < 200 && !bus.rsp_valid_o; i++) step();
        for (int i = 0; i < 10; i++) begin
            bus.cmd_valid_i = (i == 3);
            bus.cmd_addr_i = 4'($urandom);
            bus.cmd_steps_i = 8'($urandom_range(0, 3));
            step();
            check("hold_ready_low", {bus.cmd_ready_o, bus.rsp_valid_o, bus.busy_o}, 3'b011);
        end
        bus.cmd_valid_i = 1'b0;
        take_rsp(0, 10);
        repeat (3) step();
        check("no_stray_cmd", {bus.busy_o, exp_tx.size() == 0}, 2'b01);

        // reset while the control write is on the bus
        issue(4'h3, 8'd2, 28'($urandom), 1, $urandom, 0);
        for (int i = 0; i < 100 && !(bus.wbm_cyc_o && bus.wbm_adr_o == CTRL_ADR); i++) step();
        check("ctrl_tx_seen", {bus.wbm_cyc_o, bus.wbm_adr_o}, {1'b1, CTRL_ADR});
        do_reset();
        repeat (4) step();
        check("no_rsp_after_reset", {bus.rsp_valid_o, bus.busy_o}, 2'b00);
        run_cmd(4'($urandom), 8'd1, 28'($urandom), -1, $urandom, 1);

        for (int c = 0; c < 30; c++) begin
            logic [7:0] s;
            int         k;
            s = $urandom_range(0, 7) == 0 ? 8'($urandom_range(8, 40)) : 8'($urandom_range(0, 4));
            k = $urandom_range(0, 4) == 0 ? int'($urandom_range(0, 2 + 2 * int'(s))) : -1;
            run_cmd(4'($urandom), s, 28'($urandom), k, $urandom, $urandom_range(0, 3));
        end

        repeat (5) step();
        check("exp_tx_drained", exp_tx.size(), 0);
        check("exp_rsp_drained", exp_rsp.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
